// File: rtl/mouse_frame_ctl_if.sv
// rtl/mouse_frame_ctl_if.sv - VGA timing interface carrying the raster counters
//
// Signals:
//   vcount  current line number
//   hcount  current pixel within the line
// Modports:
//   in   consumer of the timing stream
//   out  producer of the timing stream

interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;

    modport in  (input  vcount, input  hcount);
    modport out (output vcount, output hcount);
endinterface

// File: rtl/mouse_frame_ctl.sv
// rtl/mouse_frame_ctl.sv - frame-stable mouse position and debounced button events
//
// Filters the raw MouseCtl position and button into values that only change
// once per video frame, plus click/drag events.
//
// Ports:
//   clk         pixel clock (clk_40 domain), all state on rising edge
//   rst         synchronous active-high reset
//   vga_in      timing stream, only vcount/hcount are used
//   mouse_xpos  raw x position (may be caught mid-transition)
//   mouse_ypos  raw y position (may be caught mid-transition)
//   mouse_left  raw left button level
//   xpos, ypos  clamped position, updated once per frame
//   left_held   debounced button level
//   click       one-cycle pulse on a debounced press
//   drag        button held and latched position moved since the press

module mouse_frame_ctl #(
    parameter int X_MAX      = 799,
    parameter int Y_MAX      = 599,
    parameter int V_LATCH    = 600,
    parameter int STABLE_CNT = 2,
    parameter int DEB_CYCLES = 40000
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left_held,
    output logic        click,
    output logic        drag
);

    localparam int SW = (STABLE_CNT < 1) ? 1 : $clog2(STABLE_CNT + 1);
    localparam int DW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);

    localparam logic [SW-1:0] STAB_TGT  = SW'(STABLE_CNT);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_SAT   = DW'(DEB_CYCLES);
    localparam logic [11:0]   X_MAX_L   = 12'(X_MAX);
    localparam logic [11:0]   Y_MAX_L   = 12'(Y_MAX);
    localparam logic [10:0]   V_LATCH_L = 11'(V_LATCH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    // Sample stage
    logic [11:0] s_x;
    logic [11:0] s_y;
    logic        s_left;

    // Stability filter
    logic [11:0]   cand_x;
    logic [11:0]   cand_y;
    logic [SW-1:0] stab_cnt;
    logic [11:0]   pend_x;
    logic [11:0]   pend_y;

    // Button / frame state
    btn_state_t  state;
    logic [DW-1:0] deb_cnt;
    logic [11:0] click_x;
    logic [11:0] click_y;
    logic        latch_now;

    assign latch_now = (vga_in.vcount == V_LATCH_L) && (vga_in.hcount == 11'd0);

    // The raw inputs come from another register stage that can be caught
    // mid-update; one local register gives every comparison a settled value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_x    <= 12'd0;
            s_y    <= 12'd0;
            s_left <= 1'b0;
        end else begin
            s_x    <= mouse_xpos;
            s_y    <= mouse_ypos;
            s_left <= mouse_left;
        end
    end

    // A position is accepted only after STABLE_CNT identical samples in a row.
    // The counter saturates at the target, so a long stable run keeps
    // re-writing the same value into pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_x   <= 12'd0;
            cand_y   <= 12'd0;
            stab_cnt <= '0;
            pend_x   <= 12'd0;
            pend_y   <= 12'd0;
        end else begin
            if (s_x == cand_x && s_y == cand_y) begin
                if (stab_cnt != STAB_TGT) begin
                    stab_cnt <= stab_cnt + SW'(1);
                end
            end else begin
                cand_x   <= s_x;
                cand_y   <= s_y;
                stab_cnt <= SW'(1);
            end

            if (stab_cnt == STAB_TGT) begin
                pend_x <= (cand_x > X_MAX_L) ? X_MAX_L : cand_x;
                pend_y <= (cand_y > Y_MAX_L) ? Y_MAX_L : cand_y;
            end
        end
    end

    // Frame latch and button FSM share one block because both write drag.
    // The drag clear on entry to IDLE is written after the latch evaluation
    // so it wins when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos      <= 12'd0;
            ypos      <= 12'd0;
            state     <= IDLE;
            deb_cnt   <= '0;
            click_x   <= 12'd0;
            click_y   <= 12'd0;
            left_held <= 1'b0;
            click     <= 1'b0;
            drag      <= 1'b0;
        end else begin
            click <= 1'b0;

            if (latch_now) begin
                xpos <= pend_x;
                ypos <= pend_y;
                drag <= left_held && ((pend_x != click_x) || (pend_y != click_y));
            end

            case (state)
                IDLE: begin
                    if (s_left) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_left) begin
                        state <= IDLE;
                        drag  <= 1'b0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        left_held <= 1'b1;
                        click     <= 1'b1;
                        click_x   <= pend_x;
                        click_y   <= pend_y;
                    end else if (deb_cnt != DEB_SAT) begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!s_left) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s_left) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= IDLE;
                        left_held <= 1'b0;
                        drag      <= 1'b0;
                    end else if (deb_cnt != DEB_SAT) begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_frame_ctl.sv
// tb/tb_mouse_frame_ctl.sv - scoreboard bench for mouse_frame_ctl

module tb_mouse_frame_ctl;

    localparam int X_MAX      = 799;
    localparam int Y_MAX      = 599;
    localparam int V_LATCH    = 600;
    localparam int STABLE_CNT = 2;
    localparam int DEB_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mx;
    logic [11:0] my;
    logic        ml;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left_held;
    logic        click;
    logic        drag;

    vga_if vga ();

    always #5 clk = ~clk;

    mouse_frame_ctl #(
        .X_MAX      (X_MAX),
        .Y_MAX      (Y_MAX),
        .V_LATCH    (V_LATCH),
        .STABLE_CNT (STABLE_CNT),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (vga),
        .mouse_xpos (mx),
        .mouse_ypos (my),
        .mouse_left (ml),
        .xpos       (xpos),
        .ypos       (ypos),
        .left_held  (left_held),
        .click      (click),
        .drag       (drag)
    );

    typedef struct {
        int x;
        int y;
        int held;
        int drag;
    } st_t;

    st_t st_q[$];
    int  click_q[$];
    st_t mon_e;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int clicks_seen = 0;

    // Reference model state (plain integers, pipeline expressed as history)
    int m_pend_x, m_pend_y, m_xpos, m_ypos, m_clk_x, m_clk_y;
    int m_held, m_drag, m_deb, m_prev_l;
    int h_x[$];
    int h_y[$];
    int h_run[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int clamp(input int v, input int mx_v);
        return (v > mx_v) ? mx_v : v;
    endfunction

    task automatic model_reset();
        m_pend_x = 0; m_pend_y = 0;
        m_xpos = 0; m_ypos = 0;
        m_clk_x = 0; m_clk_y = 0;
        m_held = 0; m_drag = 0; m_deb = 0; m_prev_l = 0;
        h_x.delete(); h_y.delete(); h_run.delete();
        // The value seen just after reset is 0, counted once.
        h_x.push_back(0); h_y.push_back(0); h_run.push_back(1);
    endtask

    // Model of one clock edge, using the inputs that were present at it.
    // Pending = clamp of a raw value seen STABLE_CNT times in a row, two edges
    // later; the button flips after DEB_CYCLES+1 consecutive opposite samples,
    // one edge after the raw input.
    task automatic model_edge();
        int cx, cy, run, old_px, old_py, b;
        bit latch;
        if (rst) begin
            model_reset();
        end else begin
            cx = int'(mx);
            cy = int'(my);
            latch = (int'(vga.vcount) == V_LATCH) && (int'(vga.hcount) == 0);
            old_px = m_pend_x;
            old_py = m_pend_y;
            if (latch) begin
                m_xpos = old_px;
                m_ypos = old_py;
                m_drag = (m_held != 0 && (old_px != m_clk_x || old_py != m_clk_y)) ? 1 : 0;
            end
            run = (cx == h_x[$] && cy == h_y[$]) ? h_run[$] + 1 : 1;
            h_x.push_back(cx); h_y.push_back(cy); h_run.push_back(run);
            if (h_x.size() > 3) begin
                void'(h_x.pop_front()); void'(h_y.pop_front()); void'(h_run.pop_front());
            end
            if (h_x.size() == 3 && h_run[0] >= STABLE_CNT) begin
                m_pend_x = clamp(h_x[0], X_MAX);
                m_pend_y = clamp(h_y[0], Y_MAX);
            end
            b = m_prev_l;
            m_prev_l = int'(ml);
            if (b != m_held) begin
                m_deb++;
                if (m_deb == DEB_CYCLES + 1) begin
                    m_held = b;
                    m_deb = 0;
                    if (b != 0) begin
                        click_q.push_back(cyc);
                        m_clk_x = old_px;
                        m_clk_y = old_py;
                    end else begin
                        m_drag = 0;
                    end
                end
            end else begin
                m_deb = 0;
            end
        end
        st_q.push_back('{x: m_xpos, y: m_ypos, held: m_held, drag: m_drag});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
    endtask

    // Monitor: compares outputs presented after every edge against the queues.
    always @(negedge clk) begin
        if (click === 1'b1) clicks_seen++;
        if (st_q.size() > 0) begin
            mon_e = st_q.pop_front();
            check("xpos", int'(xpos), mon_e.x);
            check("ypos", int'(ypos), mon_e.y);
            check("left_held", int'(left_held), mon_e.held);
            check("drag", int'(drag), mon_e.drag);
            if (click_q.size() > 0 && click_q[0] == cyc) begin
                check("click_pulse", int'(click), 1);
                void'(click_q.pop_front());
            end else if (click === 1'b1) begin
                check("click_unexpected", int'(click), 0);
            end
        end
    end

    initial begin
        int c0;
        int xhold, lhold;
        rst = 1'b1; mx = 12'd0; my = 12'd0; ml = 1'b0;
        vga.vcount = 11'd0; vga.hcount = 11'd0;
        model_reset();
        repeat (3) tick();
        check("rst_xpos", int'(xpos), 0);
        check("rst_ypos", int'(ypos), 0);
        check("rst_click", int'(click), 0);
        check("rst_drag", int'(drag), 0);
        rst = 1'b0;

        // Stable position then latch
        mx = 12'd100; my = 12'd200;
        repeat (5) tick();
        check("prelatch_x", int'(xpos), 0);
        check("prelatch_y", int'(ypos), 0);
        vga.vcount = 11'(V_LATCH); tick(); vga.vcount = 11'd0;
        check("latch_x", int'(xpos), 100);
        check("latch_y", int'(ypos), 200);

        // Toggling x is never accepted
        for (int i = 0; i < 8; i++) begin
            mx = (i % 2 == 0) ? 12'd101 : 12'd100;
            tick();
        end
        mx = 12'd101;
        vga.vcount = 11'(V_LATCH); tick(); vga.vcount = 11'd0;
        check("toggle_x", int'(xpos), 100);

        // Clamping
        mx = 12'd900;
        repeat (5) tick();
        vga.vcount = 11'(V_LATCH); tick(); vga.vcount = 11'd0;
        check("clamp_x", int'(xpos), 799);
        my = 12'd4000;
        repeat (5) tick();
        vga.vcount = 11'(V_LATCH); tick(); vga.vcount = 11'd0;
        check("clamp_y", int'(ypos), 599);

        // Short press: no click
        c0 = clicks_seen;
        ml = 1'b1; repeat (5) tick();
        ml = 1'b0; repeat (12) tick();
        check("short_held", int'(left_held), 0);
        check("short_clicks", clicks_seen - c0, 0);

        // Long press: one click
        c0 = clicks_seen;
        ml = 1'b1; repeat (12) tick();
        check("press_held", int'(left_held), 1);
        check("press_clicks", clicks_seen - c0, 1);

        // Release glitch
        c0 = clicks_seen;
        ml = 1'b0; repeat (3) tick();
        ml = 1'b1; repeat (6) tick();
        check("glitch_held", int'(left_held), 1);
        check("glitch_clicks", clicks_seen - c0, 0);
        ml = 1'b0; repeat (12) tick();
        check("release_held", int'(left_held), 0);

        // Drag
        mx = 12'd50; my = 12'd50;
        repeat (5) tick();
        c0 = clicks_seen;
        ml = 1'b1; repeat (12) tick();
        check("drag_press_clicks", clicks_seen - c0, 1);
        mx = 12'd60;
        repeat (5) tick();
        vga.vcount = 11'(V_LATCH); tick(); vga.vcount = 11'd0;
        check("drag_set", int'(drag), 1);
        check("drag_x", int'(xpos), 60);
        ml = 1'b0; repeat (12) tick();
        check("drag_clear", int'(drag), 0);
        check("drag_rel_held", int'(left_held), 0);

        // Reset mid PRESS_WAIT restarts the debounce
        c0 = clicks_seen;
        ml = 1'b1; repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_xpos", int'(xpos), 0);
        repeat (9) tick();
        check("rst_deb_early", int'(left_held), 0);
        tick();
        check("rst_deb_held", int'(left_held), 1);
        repeat (2) tick();
        check("rst_deb_clicks", clicks_seen - c0, 1);

        // Randomized traffic
        xhold = 0; lhold = 0;
        for (int i = 0; i < 700; i++) begin
            if (xhold == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    mx = 12'($urandom_range(780, 820));
                    my = 12'($urandom_range(590, 610));
                end else begin
                    mx = 12'($urandom_range(0, 4095));
                    my = 12'($urandom_range(0, 4095));
                end
                xhold = $urandom_range(1, 5);
            end
            xhold--;
            if (lhold == 0) begin
                ml = ~ml;
                lhold = $urandom_range(1, 14);
            end
            lhold--;
            vga.vcount = ($urandom_range(0, 5) == 0) ? 11'(V_LATCH) : 11'($urandom_range(0, 700));
            vga.hcount = ($urandom_range(0, 3) != 0) ? 11'd0 : 11'($urandom_range(1, 1055));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        vga.vcount = 11'd0; vga.hcount = 11'd0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("click_q_drained", click_q.size(), 0);
        check("st_q_drained", st_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
